// File: rtl/icache_pkg.sv
// Shared constants, FSM state encoding and address-split helpers for the instruction cache.
package icache_pkg;

    localparam logic [1:0] STATE_IDLE   = 2'd0;
    localparam logic [1:0] STATE_READ   = 2'd1;
    localparam logic [1:0] STATE_UPDATE = 2'd2;

    localparam logic [31:0] NOP_INSTR       = 32'h0000_0013;
    localparam logic [31:0] NO_REQUEST_ADDR = 32'hFFFF_FFFC;

    function automatic int offset_bits(input int words_per_block);
        return $clog2(words_per_block);
    endfunction

    function automatic int index_bits(input int blocks);
        return $clog2(blocks);
    endfunction

    // Byte-in-word bits [1:0] are never part of tag, index or offset.
    function automatic int tag_bits(input int blocks, input int words_per_block);
        return 32 - index_bits(blocks) - offset_bits(words_per_block) - 2;
    endfunction

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage: one combinational read port, one synchronous write port.
module icache_line_array
    import icache_pkg::*;
#(
    parameter int BLOCKS          = 8,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int TAG_W           = 25,
    parameter int IDX_W           = 3
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic [IDX_W-1:0]             rd_index,
    output logic                         rd_valid,
    output logic [TAG_W-1:0]             rd_tag,
    output logic [32*WORDS_PER_BLOCK-1:0] rd_data,
    input  logic                         wr_en,
    input  logic [IDX_W-1:0]             wr_index,
    input  logic [TAG_W-1:0]             wr_tag,
    input  logic [32*WORDS_PER_BLOCK-1:0] wr_data
);

    logic [BLOCKS-1:0]                valid_bits;
    logic [TAG_W-1:0]                 tag_mem  [BLOCKS];
    logic [32*WORDS_PER_BLOCK-1:0]    data_mem [BLOCKS];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid_bits <= '0;
        end else if (wr_en) begin
            valid_bits[wr_index] <= 1'b1;
        end
    end

    // Tag and data contents need no reset: valid gates every use of them.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid_bits[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache with block refill from instruction memory.
// Define ICACHE_STATS_EN to add saturating HIT_COUNT / MISS_COUNT outputs.
module instruction_cache
    import icache_pkg::*;
#(
    parameter int BLOCKS          = 8,
    parameter int WORDS_PER_BLOCK = 4
) (
    input  logic                                       CLK,
    input  logic                                       RESET,
    input  logic [31:0]                                ADDRESS,
    output logic [31:0]                                INSTRUCTION,
    output logic                                       BUSYWAIT,
    output logic [32-$clog2(4*WORDS_PER_BLOCK)-1:0]    MEM_ADDRESS,
    output logic                                       MEM_READ,
    input  logic [32*WORDS_PER_BLOCK-1:0]              MEM_READDATA,
    input  logic                                       MEM_BUSYWAIT
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]                                HIT_COUNT,
    output logic [31:0]                                MISS_COUNT
`endif
);

    localparam int OFF_W = offset_bits(WORDS_PER_BLOCK);
    localparam int IDX_W = index_bits(BLOCKS);
    localparam int TAG_W = tag_bits(BLOCKS, WORDS_PER_BLOCK);
    localparam int LINE_W = 32 * WORDS_PER_BLOCK;

    logic [OFF_W-1:0] addr_offset;
    logic [IDX_W-1:0] addr_index;
    logic [TAG_W-1:0] addr_tag;
    logic             unused_byte_bits;

    assign addr_offset      = ADDRESS[OFF_W+1:2];
    assign addr_index       = ADDRESS[IDX_W+OFF_W+1:OFF_W+2];
    assign addr_tag         = ADDRESS[31:IDX_W+OFF_W+2];
    assign unused_byte_bits = ^ADDRESS[1:0];

    logic [1:0]        state;
    logic [TAG_W-1:0]  fill_tag;
    logic [IDX_W-1:0]  fill_index;
    logic [LINE_W-1:0] fill_buf;

    logic              line_valid;
    logic [TAG_W-1:0]  line_tag;
    logic [LINE_W-1:0] line_data;
    logic              line_write;

    icache_line_array #(
        .BLOCKS          (BLOCKS),
        .WORDS_PER_BLOCK (WORDS_PER_BLOCK),
        .TAG_W           (TAG_W),
        .IDX_W           (IDX_W)
    ) u_lines (
        .CLK      (CLK),
        .RESET    (RESET),
        .rd_index (addr_index),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_data  (line_data),
        .wr_en    (line_write),
        .wr_index (fill_index),
        .wr_tag   (fill_tag),
        .wr_data  (fill_buf)
    );

    logic no_request;
    logic tag_hit;
    logic idle_hit;
    logic idle_miss;

    // The post-reset PC value is never looked up, even if some line's tag happens to match it.
    assign no_request = (ADDRESS == NO_REQUEST_ADDR);
    assign tag_hit    = line_valid && (line_tag == addr_tag);
    assign idle_hit   = (state == STATE_IDLE) && tag_hit && !no_request;
    assign idle_miss  = (state == STATE_IDLE) && !tag_hit && !no_request;
    assign line_write = (state == STATE_UPDATE);

    assign INSTRUCTION = (idle_hit && !RESET) ? line_data[32*addr_offset +: 32] : NOP_INSTR;
    assign BUSYWAIT    = !RESET && ((state != STATE_IDLE) || idle_miss);
    assign MEM_READ    = (state == STATE_READ);
    assign MEM_ADDRESS = (state == STATE_READ) ? {fill_tag, fill_index} : '0;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= STATE_IDLE;
            fill_tag   <= '0;
            fill_index <= '0;
            fill_buf   <= '0;
        end else begin
            case (state)
                STATE_IDLE: begin
                    if (idle_miss) begin
                        state      <= STATE_READ;
                        fill_tag   <= addr_tag;
                        fill_index <= addr_index;
                    end
                end
                STATE_READ: begin
                    if (!MEM_BUSYWAIT) begin
                        fill_buf <= MEM_READDATA;
                        state    <= STATE_UPDATE;
                    end
                end
                STATE_UPDATE: state <= STATE_IDLE;
                default:      state <= STATE_IDLE;
            endcase
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            HIT_COUNT  <= '0;
            MISS_COUNT <= '0;
        end else begin
            if (idle_hit && (HIT_COUNT != 32'hFFFF_FFFF)) begin
                HIT_COUNT <= HIT_COUNT + 32'd1;
            end
            if (idle_miss && (MISS_COUNT != 32'hFFFF_FFFF)) begin
                MISS_COUNT <= MISS_COUNT + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// Directed bench for instruction_cache: reset/idle, cold, same-line, conflict and reset-abort cases.
module tb_instruction_cache;
    import icache_pkg::*;

    logic         CLK;
    logic         RESET;
    logic [31:0]  ADDRESS;
    logic [31:0]  INSTRUCTION;
    logic         BUSYWAIT;
    logic [27:0]  MEM_ADDRESS;
    logic         MEM_READ;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT;
`ifdef ICACHE_STATS_EN
    logic [31:0]  HIT_COUNT;
    logic [31:0]  MISS_COUNT;
`endif

    int total_checks = 0;
    int pass_checks  = 0;

    instruction_cache #(
        .BLOCKS          (8),
        .WORDS_PER_BLOCK (4)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .ADDRESS      (ADDRESS),
        .INSTRUCTION  (INSTRUCTION),
        .BUSYWAIT     (BUSYWAIT),
        .MEM_ADDRESS  (MEM_ADDRESS),
        .MEM_READ     (MEM_READ),
        .MEM_READDATA (MEM_READDATA),
        .MEM_BUSYWAIT (MEM_BUSYWAIT)
`ifdef ICACHE_STATS_EN
        ,
        .HIT_COUNT    (HIT_COUNT),
        .MISS_COUNT   (MISS_COUNT)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            pass_checks++;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drives one miss on addr; memory stays busy for 'busy' READ cycles, then returns 'data'.
    task automatic do_miss(input logic [31:0] addr, input logic [27:0] exp_maddr, input int busy,
                           input logic [127:0] data, input logic [31:0] exp_word);
        ADDRESS      = addr;
        MEM_READDATA = data;
        MEM_BUSYWAIT = 1'b1;
        #1;
        check("miss_busywait", {31'd0, BUSYWAIT}, 32'd1);
        check("miss_instr_nop", INSTRUCTION, NOP_INSTR);
        check("miss_no_read_yet", {31'd0, MEM_READ}, 32'd0);
        tick();
        for (int i = 0; i < busy; i++) begin
            check("read_mem_read", {31'd0, MEM_READ}, 32'd1);
            check("read_mem_addr", {4'd0, MEM_ADDRESS}, {4'd0, exp_maddr});
            check("read_busywait", {31'd0, BUSYWAIT}, 32'd1);
            tick();
        end
        MEM_BUSYWAIT = 1'b0;
        #1;
        check("read_last_mem_read", {31'd0, MEM_READ}, 32'd1);
        check("read_last_mem_addr", {4'd0, MEM_ADDRESS}, {4'd0, exp_maddr});
        tick();
        MEM_BUSYWAIT = 1'b1;
        #1;
        check("update_busywait", {31'd0, BUSYWAIT}, 32'd1);
        check("update_mem_read", {31'd0, MEM_READ}, 32'd0);
        check("update_mem_addr", {4'd0, MEM_ADDRESS}, 32'd0);
        tick();
        check("filled_busywait", {31'd0, BUSYWAIT}, 32'd0);
        check("filled_instr", INSTRUCTION, exp_word);
    endtask

    task automatic expect_hit(input logic [31:0] addr, input logic [31:0] exp_word);
        ADDRESS = addr;
        #1;
        check("hit_instr", INSTRUCTION, exp_word);
        check("hit_busywait", {31'd0, BUSYWAIT}, 32'd0);
        check("hit_mem_read", {31'd0, MEM_READ}, 32'd0);
        tick();
    endtask

    initial begin
        RESET        = 1'b1;
        ADDRESS      = NO_REQUEST_ADDR;
        MEM_BUSYWAIT = 1'b1;
        MEM_READDATA = '0;

        tick();
        tick();
        check("rst_busywait", {31'd0, BUSYWAIT}, 32'd0);
        check("rst_mem_read", {31'd0, MEM_READ}, 32'd0);
        check("rst_mem_addr", {4'd0, MEM_ADDRESS}, 32'd0);
        check("rst_instr", INSTRUCTION, NOP_INSTR);
        RESET = 1'b0;
        tick();
        check("idle_busywait", {31'd0, BUSYWAIT}, 32'd0);
        check("idle_mem_read", {31'd0, MEM_READ}, 32'd0);
        check("idle_instr", INSTRUCTION, NOP_INSTR);
        check("idle_state", {30'd0, dut.state}, {30'd0, STATE_IDLE});
`ifdef ICACHE_STATS_EN
        check("idle_hit_count", HIT_COUNT, 32'd0);
        check("idle_miss_count", MISS_COUNT, 32'd0);
`endif

        // Cold miss: busy in cycles 0..4, data in cycle 5, hit in cycle 7.
        do_miss(32'h0, 28'h0, 4, {32'h4, 32'h3, 32'h2, 32'h1}, 32'h1);
        tick();

        expect_hit(32'h4, 32'h2);
        expect_hit(32'h8, 32'h3);
        expect_hit(32'hC, 32'h4);

        // Same index, different tag: evicts line 0.
        do_miss(32'h80, 28'h8, 2, {32'h8, 32'h7, 32'h6, 32'h5}, 32'h5);
        tick();

        // Returning to 0 misses again; memory answers in the first READ cycle.
        do_miss(32'h0, 28'h0, 0, {32'h4, 32'h3, 32'h2, 32'h1}, 32'h1);
        tick();

        // Byte-in-word bits are ignored.
        expect_hit(32'h7, 32'h2);

`ifdef ICACHE_STATS_EN
        check("stats_hit_count", HIT_COUNT, 32'd7);
        check("stats_miss_count", MISS_COUNT, 32'd3);
`endif

        // Reset while memory is still busy abandons the fill.
        ADDRESS      = 32'h10;
        MEM_BUSYWAIT = 1'b1;
        #1;
        check("abort_miss_busywait", {31'd0, BUSYWAIT}, 32'd1);
        tick();
        check("abort_mem_read", {31'd0, MEM_READ}, 32'd1);
        check("abort_mem_addr", {4'd0, MEM_ADDRESS}, 32'd1);
        RESET = 1'b1;
        #1;
        check("abort_rst_busywait", {31'd0, BUSYWAIT}, 32'd0);
        tick();
        check("abort_after_mem_read", {31'd0, MEM_READ}, 32'd0);
        check("abort_after_mem_addr", {4'd0, MEM_ADDRESS}, 32'd0);
        check("abort_after_state", {30'd0, dut.state}, {30'd0, STATE_IDLE});
`ifdef ICACHE_STATS_EN
        check("rst_hit_count", HIT_COUNT, 32'd0);
        check("rst_miss_count", MISS_COUNT, 32'd0);
`endif
        RESET = 1'b0;

        // Valid bits were cleared, so address 0 misses again.
        do_miss(32'h0, 28'h0, 1, {32'hD, 32'hC, 32'hB, 32'hA}, 32'hA);
        tick();
        expect_hit(32'hC, 32'hD);
`ifdef ICACHE_STATS_EN
        check("final_miss_count", MISS_COUNT, 32'd1);
        check("final_hit_count", HIT_COUNT, 32'd2);
`endif

        $display("%0d/%0d checks passed", pass_checks, total_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
